regfile_write_arbiter: RTL

- Shares the single write port of the 32x32 register file between NREQ requesters, e.g. ALU writeback, load unit and debug/config.
- Each cycle it picks one valid request in round-robin order and registers it onto the register-file write port.
- It forwards in-flight write data to the read path so that the 32-to-1 read muxes never return a stale word.

---
 rtl/regfile_write_arbiter.sv | 100 ++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between NREQ requesters,
// with a one-stage registered write port and write-to-read forwarding.
module regfile_write_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ADDRW = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*ADDRW-1:0]  req_addr,
  input  logic [NREQ*WIDTH-1:0]  req_data,
  output logic                   wr_en,
  output logic [ADDRW-1:0]       wr_addr,
  output logic [WIDTH-1:0]       wr_data,
  output logic [2:0]             wr_src,
  input  logic [ADDRW-1:0]       rd_addr,
  input  logic [WIDTH-1:0]       rf_rd_data,
  output logic [WIDTH-1:0]       rd_data,
  output logic [7:0]             drop_cnt
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]    ptr_q, ptr_d;
  logic [NREQ-1:0]  grant;
  logic [PW-1:0]    gidx;
  logic             found;
  logic [ADDRW-1:0] sel_addr;
  logic [WIDTH-1:0] sel_data;

  // Scan from ptr upward, wrapping modulo NREQ; first valid requester wins.
  always_comb begin
    logic [PW:0] sum;
    sum   = '0;
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr_q} + (PW+1)'(k);
      if (32'(sum) >= NREQ) begin
        sum = sum - (PW+1)'(NREQ);
      end
      if (!found && req_valid[sum[PW-1:0]]) begin
        found                = 1'b1;
        gidx                 = sum[PW-1:0];
        grant[sum[PW-1:0]]   = 1'b1;
      end
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (grant[k]) begin
        sel_addr = req_addr[k*ADDRW +: ADDRW];
        sel_data = req_data[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (found) begin
      ptr_d = (32'(gidx) == NREQ - 1) ? '0 : gidx + PW'(1);
    end
  end

  assign req_ready = rst_n ? grant : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q    <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      wr_src   <= '0;
      drop_cnt <= '0;
    end else begin
      ptr_q <= ptr_d;
      wr_en <= 1'b0;
      if (found) begin
        if (sel_addr != '0) begin
          wr_en   <= 1'b1;
          wr_addr <= sel_addr;
          wr_data <= sel_data;
          wr_src  <= 3'(gidx);
        end else if (drop_cnt != 8'hff) begin
          // Register 0 is hardwired to zero; just count the discarded write.
          drop_cnt <= drop_cnt + 8'd1;
        end
      end
    end
  end

  assign rd_data = (wr_en && (rd_addr == wr_addr) && (rd_addr != '0)) ? wr_data : rf_rd_data;

endmodule
